// File: rtl/tester_gtx_rx_mon.sv
// GTX RX pattern monitor: locks on the incrementing data pattern and reports errors per window.
// Optional TESTER_GTX_RX_MON_TOTAL_EN builds the saturating total error counter.
module tester_gtx_rx_mon_lane #(
  parameter logic [15:0] IDLE = 16'h02bc
) (
  input  logic [15:0] lane_data,
  input  logic [1:0]  lane_char,
  output logic        lane_idle
);
  assign lane_idle = (lane_char == 2'b01) && (lane_data == IDLE);
endmodule

module tester_gtx_rx_mon #(
  parameter int          DW         = 16,
  parameter logic [15:0] IDLE       = 16'h02bc,
  parameter int          WIN_LEN    = 10000,
  parameter int          LOCK_CNT   = 8,
  parameter int          UNLOCK_CNT = 4,
  parameter int          CW         = 16
) (
  input  logic              usrclk,
  input  logic              usrrst_n,
  input  logic [DW-1:0]     rx_data,
  input  logic [DW/8-1:0]   rx_char,
  input  logic              clr,
  output logic              locked,
  output logic              err_flag,
  output logic [CW-1:0]     der,
  output logic              der_vld,
  output logic [31:0]       err_total
);
  localparam int NL = DW / 16;
  localparam int WW = $clog2(WIN_LEN);
  localparam int RW = $clog2(LOCK_CNT);
  localparam int BW = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT) : 1;

  typedef enum logic {HUNT = 1'b0, SYNC = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   run_q, run_d;
  logic [BW-1:0]   bad_q, bad_d;
  logic [DW-1:0]   ref_q;
  logic [WW-1:0]   win_q;
  logic [CW-1:0]   win_err_q, win_err_nxt;
  logic [NL-1:0]   lane_idle;
  logic            is_data, is_idle, is_good, is_err;
  logic            in_sync, sync_err, unlock, win_end;

  for (genvar l = 0; l < NL; l++) begin : g_lane
    tester_gtx_rx_mon_lane #(.IDLE(IDLE)) u_lane (
      .lane_data (rx_data[16*l +: 16]),
      .lane_char (rx_char[2*l +: 2]),
      .lane_idle (lane_idle[l])
    );
  end

  // Anything that is neither pure data nor a full idle word counts as BAD.
  assign is_data = (rx_char == '0);
  assign is_idle = &lane_idle;
  assign is_good = is_data && (rx_data == ref_q + DW'(1));
  assign is_err  = !is_idle && !is_good;

  always_ff @(posedge usrclk or negedge usrrst_n) begin
    if (!usrrst_n) begin
      state_q <= HUNT;
      run_q   <= '0;
      bad_q   <= '0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      bad_q   <= bad_d;
      if (is_data) ref_q <= rx_data;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    bad_d   = bad_q;
    case (state_q)
      HUNT: begin
        if (is_good) begin
          if (run_q == RW'(LOCK_CNT - 1)) begin
            state_d = SYNC;
            run_d   = '0;
          end else begin
            run_d = run_q + RW'(1);
          end
        end else if (!is_idle) begin
          run_d = '0;
        end
      end
      SYNC: begin
        if (is_err) begin
          if (bad_q == BW'(UNLOCK_CNT - 1)) begin
            state_d = HUNT;
            bad_d   = '0;
          end else begin
            bad_d = bad_q + BW'(1);
          end
        end else if (is_good) begin
          bad_d = '0;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    in_sync  = (state_q == SYNC);
    sync_err = in_sync && is_err;
    unlock   = sync_err && (bad_q == BW'(UNLOCK_CNT - 1));
    win_end  = in_sync && is_data && (win_q == WW'(WIN_LEN - 1));
  end

  assign locked      = (state_q == SYNC);
  assign win_err_nxt = (sync_err && (win_err_q != '1)) ? win_err_q + CW'(1) : win_err_q;

  // Priority: clr, then unlock, then window end; lock loss discards the partial window.
  always_ff @(posedge usrclk or negedge usrrst_n) begin
    if (!usrrst_n) begin
      err_flag  <= 1'b0;
      win_q     <= '0;
      win_err_q <= '0;
      der       <= '0;
      der_vld   <= 1'b0;
    end else begin
      err_flag <= sync_err;
      der_vld  <= 1'b0;
      if (clr) begin
        win_q     <= '0;
        win_err_q <= '0;
        der       <= '0;
      end else if (unlock) begin
        win_q     <= '0;
        win_err_q <= '0;
      end else if (win_end) begin
        der       <= win_err_nxt;
        der_vld   <= 1'b1;
        win_q     <= '0;
        win_err_q <= '0;
      end else if (in_sync) begin
        if (is_data) win_q <= win_q + WW'(1);
        win_err_q <= win_err_nxt;
      end
    end
  end

`ifdef TESTER_GTX_RX_MON_TOTAL_EN
  logic [31:0] total_q;
  always_ff @(posedge usrclk or negedge usrrst_n) begin
    if (!usrrst_n)                         total_q <= '0;
    else if (clr)                          total_q <= '0;
    else if (sync_err && total_q != '1)    total_q <= total_q + 32'd1;
  end
  assign err_total = total_q;
`else
  assign err_total = 32'd0;
`endif
endmodule

// File: tb/tb_tester_gtx_rx_mon.sv
// Bench for tester_gtx_rx_mon: a DW=16 and a DW=32 instance driven by directed and random
// words, checked every cycle against a behavioural model of the monitor.
module tb_tester_gtx_rx_mon;
  localparam int WIN  = 16;
  localparam int LOCK = 4;
  localparam longint MAX32 = 64'hFFFF_FFFF;
`ifdef TESTER_GTX_RX_MON_TOTAL_EN
  localparam bit TOT_EN = 1'b1;
`else
  localparam bit TOT_EN = 1'b0;
`endif

  logic usrclk = 1'b0;
  logic usrrst_n;
  always #5 usrclk = ~usrclk;

  logic [15:0] d0;  logic [1:0] c0;  logic clr0;
  logic [31:0] d1;  logic [3:0] c1;  logic clr1;
  logic locked0, err_flag0, der_vld0;  logic [7:0] der0;  logic [31:0] tot0;
  logic locked1, err_flag1, der_vld1;  logic [3:0] der1;  logic [31:0] tot1;

  tester_gtx_rx_mon #(.DW(16), .IDLE(16'h02bc), .WIN_LEN(WIN), .LOCK_CNT(LOCK),
                      .UNLOCK_CNT(3), .CW(8)) dut0 (
    .usrclk(usrclk), .usrrst_n(usrrst_n), .rx_data(d0), .rx_char(c0), .clr(clr0),
    .locked(locked0), .err_flag(err_flag0), .der(der0), .der_vld(der_vld0), .err_total(tot0));

  tester_gtx_rx_mon #(.DW(32), .IDLE(16'h02bc), .WIN_LEN(WIN), .LOCK_CNT(LOCK),
                      .UNLOCK_CNT(1000), .CW(4)) dut1 (
    .usrclk(usrclk), .usrrst_n(usrrst_n), .rx_data(d1), .rx_char(c1), .clr(clr1),
    .locked(locked1), .err_flag(err_flag1), .der(der1), .der_vld(der_vld1), .err_total(tot1));

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Model state per instance
  int     P_DW[2]    = '{16, 32};
  int     P_UNL[2]   = '{3, 1000};
  int     P_CWMAX[2] = '{255, 15};
  longint m_ref[2]   = '{0, 0};
  longint m_tot[2]   = '{0, 0};
  int     m_run[2]   = '{0, 0};
  int     m_bad[2]   = '{0, 0};
  int     m_win[2]   = '{0, 0};
  int     m_werr[2]  = '{0, 0};
  int     m_der[2]   = '{0, 0};
  bit     m_lock[2]  = '{0, 0};
  bit     e_err[2]   = '{0, 0};
  bit     e_vld[2]   = '{0, 0};

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint nxt(int i);
    return (m_ref[i] + 1) & ((64'd1 << P_DW[i]) - 1);
  endfunction

  task automatic model(int i, longint d, int c, bit clr);
    longint mask;
    bit is_data, is_idle, good, e, unl;
    mask    = (64'd1 << P_DW[i]) - 1;
    is_data = (c == 0);
    is_idle = (i == 0) ? (c == 1 && d == 64'h02bc) : (c == 5 && d == 64'h02bc02bc);
    good    = is_data && (d == nxt(i));
    e_err[i] = 0; e_vld[i] = 0; unl = 0;
    if (m_lock[i]) begin
      e = !is_idle && !good;
      e_err[i] = e;
      if (e) begin
        m_bad[i]++;
        if (m_bad[i] == P_UNL[i]) begin m_lock[i] = 0; m_bad[i] = 0; unl = 1; end
      end else if (good) m_bad[i] = 0;
      if (clr) begin
        m_win[i] = 0; m_werr[i] = 0; m_der[i] = 0; m_tot[i] = 0;
      end else begin
        if (e && m_tot[i] < MAX32) m_tot[i]++;
        if (unl) begin
          m_win[i] = 0; m_werr[i] = 0;
        end else begin
          if (e && m_werr[i] < P_CWMAX[i]) m_werr[i]++;
          if (is_data) begin
            m_win[i]++;
            if (m_win[i] == WIN) begin
              m_der[i] = m_werr[i]; e_vld[i] = 1; m_win[i] = 0; m_werr[i] = 0;
            end
          end
        end
      end
    end else begin
      if (good) begin
        m_run[i]++;
        if (m_run[i] == LOCK) begin m_lock[i] = 1; m_run[i] = 0; end
      end else if (!is_idle) m_run[i] = 0;
      if (clr) begin m_win[i] = 0; m_werr[i] = 0; m_der[i] = 0; m_tot[i] = 0; end
    end
    if (is_data) m_ref[i] = d & mask;
  endtask

  task automatic check_all();
    chk("locked0",   locked0,   m_lock[0]);
    chk("err_flag0", err_flag0, e_err[0]);
    chk("der0",      der0,      m_der[0]);
    chk("der_vld0",  der_vld0,  e_vld[0]);
    chk("total0",    tot0,      TOT_EN ? m_tot[0] : 0);
    chk("locked1",   locked1,   m_lock[1]);
    chk("err_flag1", err_flag1, e_err[1]);
    chk("der1",      der1,      m_der[1]);
    chk("der_vld1",  der_vld1,  e_vld[1]);
    chk("total1",    tot1,      TOT_EN ? m_tot[1] : 0);
  endtask

  // Drive one word into instance i; the other instance sees an idle word.
  task automatic step(int i, longint d, int c, bit clr);
    if (i == 0) begin
      d0 = d[15:0]; c0 = c[1:0]; clr0 = clr;
      d1 = 32'h02bc02bc; c1 = 4'h5; clr1 = 1'b0;
      model(0, d, c, clr); model(1, 64'h02bc02bc, 5, 0);
    end else begin
      d1 = d[31:0]; c1 = c[3:0]; clr1 = clr;
      d0 = 16'h02bc; c0 = 2'h1; clr0 = 1'b0;
      model(1, d, c, clr); model(0, 64'h02bc, 1, 0);
    end
    @(posedge usrclk); #1;
    check_all();
  endtask

  initial begin
    int vld_cnt;
    longint base;
    usrrst_n = 1'b0;
    d0 = 16'h02bc; c0 = 2'h1; clr0 = 1'b0;
    d1 = 32'h02bc02bc; c1 = 4'h5; clr1 = 1'b0;
    repeat (3) @(posedge usrclk);
    #1;
    check_all();
    usrrst_n = 1'b1;

    // Lock on 0..4
    for (int v = 0; v <= 4; v++) begin
      step(0, v, 0, 0);
      if (v == 3) chk("lock_before4", locked0, 1'b0);
    end
    chk("lock_after4", locked0, 1'b1);

    // Full good window with an idle word inside
    vld_cnt = 0;
    for (int k = 0; k < 17; k++) begin
      if (k == 7) step(0, 64'h02bc, 1, 0);
      else        step(0, nxt(0), 0, 0);
      vld_cnt += int'(der_vld0);
    end
    chk("idle_win_vld_cnt", vld_cnt, 1);
    chk("idle_win_der", der0, 0);

    // Word 5 of a window replaced by 0x00aa
    for (int k = 0; k < 20 && m_win[0] != 0; k++) step(0, nxt(0), 0, 0);
    for (int k = 0; k < 5; k++) step(0, nxt(0), 0, 0);
    base = m_ref[0];
    step(0, 64'h00aa, 0, 0);
    chk("aa_err_flag", err_flag0, 1'b1);
    step(0, base + 2, 0, 0);
    chk("aa_next_err_flag", err_flag0, 1'b1);
    step(0, base + 3, 0, 0);
    chk("aa_recover_err_flag", err_flag0, 1'b0);
    vld_cnt = 0;
    for (int k = 0; k < 20 && vld_cnt == 0; k++) begin
      step(0, nxt(0), 0, 0);
      vld_cnt += int'(der_vld0);
    end
    chk("aa_vld_seen", vld_cnt, 1);
    chk("aa_der", der0, 2);

    // Three BAD words drop lock
    for (int k = 0; k < 3; k++) step(0, $urandom_range(0, 65535), 2, 0);
    chk("bad_unlock", locked0, 1'b0);
    chk("bad_der_kept", der0, 2);
    chk("bad_no_vld", der_vld0, 1'b0);

    // Relock, then clr on a window-end word carrying an error
    for (int k = 0; k < 4; k++) step(0, nxt(0), 0, 0);
    chk("relock", locked0, 1'b1);
    for (int k = 0; k < 20 && m_win[0] != WIN - 1; k++) step(0, nxt(0), 0, 0);
    step(0, nxt(0) + 7, 0, 1);
    chk("clr_der", der0, 0);
    chk("clr_vld", der_vld0, 1'b0);
    chk("clr_total", tot0, 0);
    chk("clr_locked", locked0, 1'b1);

    // Random traffic on both instances
    for (int n = 0; n < 400; n++) begin
      int i, r, c;
      longint d;
      i = ($urandom_range(0, 3) == 0) ? 1 : 0;
      r = $urandom_range(0, 99);
      if (r < 70)      step(i, nxt(i), 0, 0);
      else if (r < 80) step(i, (nxt(i) + $urandom_range(1, 1000)) & ((64'd1 << P_DW[i]) - 1), 0, 0);
      else if (r < 88) step(i, (i == 0) ? 64'h02bc : 64'h02bc02bc, (i == 0) ? 1 : 5, 0);
      else if (r < 95) begin
        c = (i == 0) ? $urandom_range(1, 3) : $urandom_range(1, 15);
        if (i == 1 && c == 5) c = 4;
        d = (c == 1 && i == 0) ? 64'h02bd : longint'($urandom);
        step(i, d & ((64'd1 << P_DW[i]) - 1), c, 0);
      end else         step(i, nxt(i), 0, 1);
    end

    // DW=32: lock, then every word mismatched for 20+ windows
    for (int k = 0; k < 5; k++) step(1, nxt(1), 0, 0);
    chk("dw32_locked", locked1, 1'b1);
    for (int k = 0; k < 20 * WIN + 10; k++)
      step(1, (nxt(1) + 1) & 64'hFFFF_FFFF, 0, 0);
    chk("dw32_der_sat", der1, 15);
    chk("dw32_total", tot1, TOT_EN ? m_tot[1] : 0);
    chk("dw32_still_locked", locked1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
